rect_fill_ctrl: RTL and testbench

Parametrised rectangle-fill controller for the VGA plotting path. It takes a rectangle (x0, y0)–(x1, y1) and a colour over a start/done handshake, then emits one pixel per clock, in raster order, to the VGA adapter's plot interface. The controller owns its own x/y counters and done detection, so no external datapath is required. It also adds clipping, empty-rectangle handling, abort, and a busy status, which makes it the general replacement for the fixed full-screen clear sequencer.

---
 rtl/rect_fill_ctrl.sv | 128 ++++++++++++
 tb/tb_rect_fill_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_ctrl.sv
// Rectangle-fill controller: plots one clipped pixel per clock in raster order.
// Includes empty-rectangle detection, abort and a one-cycle done pulse.
module rect_fill_ctrl #(
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] colour_in,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XW-1:0] XLIM = XW'(XMAX);
  localparam logic [YW-1:0] YLIM = YW'(YMAX);

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0] y0_q, y0_d, y1_q, y1_d;
  logic [CW-1:0] col_q, col_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic [XW-1:0] x1c;
  logic [YW-1:0] y1c;
  logic          empty;

  assign x1c = (x1_q > XLIM) ? XLIM : x1_q;
  assign y1c = (y1_q > YLIM) ? YLIM : y1_q;

  assign empty = (x0_q > x1c) || (y0_q > y1c) ||
                 (x0_q > XLIM) || (y0_q > YLIM);

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    col_d   = col_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = x0;
          x1_d    = x1;
          y0_d    = y0;
          y1_d    = y1;
          col_d   = colour_in;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (empty) begin
          state_d = S_DONE;
        end else begin
          x_d     = x0_q;
          y_d     = y0_q;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // abort outranks the last-pixel transition
        if (abort) begin
          state_d = S_IDLE;
        end else if (x_q != x1c) begin
          x_d = x_q + XW'(1);
        end else if (y_q != y1c) begin
          x_d = x0_q;
          y_d = y_q + YW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      col_q   <= col_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign plot   = (state_q == S_FILL);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign x      = x_q;
  assign y      = y_q;
  assign colour = col_q;

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Bench for rect_fill_ctrl: queue-based cycle model plus literal pixel checks.
// Random rectangles, aborts and stray starts are mixed with directed cases.
module tb_rect_fill_ctrl;

  logic       clock, resetb, start, abort;
  logic [7:0] x0, x1, x;
  logic [6:0] y0, y1, y;
  logic [2:0] colour_in, colour;
  logic       plot, busy, done;

  rect_fill_ctrl dut (
    .clock(clock), .resetb(resetb), .start(start), .abort(abort),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .colour_in(colour_in),
    .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One entry per busy cycle: LOAD, each plotted pixel, then DONE.
  typedef struct {
    int plot;
    int done;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t mq[$];
  exp_t me;

  task automatic build();
    int cx, cy;
    cx = (int'(x1) > 159) ? 159 : int'(x1);
    cy = (int'(y1) > 119) ? 119 : int'(y1);
    mq.push_back('{0, 0, 0, 0, 0});
    if (!(int'(x0) > cx || int'(y0) > cy))
      for (int yy = int'(y0); yy <= cy; yy++)
        for (int xx = int'(x0); xx <= cx; xx++)
          mq.push_back('{1, 0, xx, yy, int'(colour_in)});
    mq.push_back('{0, 1, 0, 0, 0});
  endtask

  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (start) build();
    end else begin
      me = mq.pop_front();
      if (me.plot != 0 && abort) mq.delete();
    end
  end

  always @(negedge clock) begin
    if (resetb) begin
      if (mq.size() == 0) begin
        check("ctl", {29'd0, busy, plot, done}, 0);
      end else begin
        check("ctl", {29'd0, busy, plot, done},
              {29'd0, 1'b1, mq[0].plot[0], mq[0].done[0]});
        if (mq[0].plot != 0)
          check("pix", {14'd0, x, y, colour},
                {14'd0, 8'(mq[0].x), 7'(mq[0].y), 3'(mq[0].c)});
      end
    end
  end

  typedef struct {
    int rel;
    int x;
    int y;
    int c;
  } cap_t;

  cap_t caplog[$];
  int   cyc = 0;
  int   t0 = 0;
  int   done_rel = -1;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (resetb) begin
      if (plot) caplog.push_back('{cyc - t0, int'(x), int'(y), int'(colour)});
      if (done) done_rel = cyc - t0;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic go(int ax0, int ay0, int ax1, int ay1, int ac);
    caplog.delete();
    done_rel  = -1;
    x0        = 8'(ax0);
    y0        = 7'(ay0);
    x1        = 8'(ax1);
    y1        = 7'(ay1);
    colour_in = 3'(ac);
    start     = 1;
    t0        = cyc;
    step();
    start     = 0;
    x0        = 8'($urandom);
    y0        = 7'($urandom);
    x1        = 8'($urandom);
    y1        = 7'($urandom);
    colour_in = 3'($urandom);
  endtask

  task automatic wait_done(int lim);
    for (int i = 0; i < lim && done_rel < 0; i++) step();
    check("done_seen", done_rel >= 0, 1);
  endtask

  task automatic check_outs_zero(string nm);
    check({nm, "_plot"}, plot, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
    check({nm, "_x"}, x, 0);
    check({nm, "_y"}, y, 0);
    check({nm, "_col"}, colour, 0);
  endtask

  int rx[6] = '{5, 6, 5, 6, 5, 6};
  int ry[6] = '{10, 10, 11, 11, 12, 12};
  int cx[4] = '{158, 159, 158, 159};
  int cy[4] = '{118, 118, 119, 119};

  initial begin
    resetb = 0; start = 0; abort = 0;
    x0 = 0; y0 = 0; x1 = 0; y1 = 0; colour_in = 0;
    repeat (3) step();
    check_outs_zero("rst");
    resetb = 1;
    repeat (2) step();

    go(5, 10, 6, 12, 5);
    wait_done(50);
    check("rect_n", caplog.size(), 6);
    for (int i = 0; i < caplog.size() && i < 6; i++) begin
      check("rect_px", caplog[i].x * 65536 + caplog[i].y * 256 + caplog[i].rel,
            rx[i] * 65536 + ry[i] * 256 + 2 + i);
      check("rect_col", caplog[i].c, 5);
    end
    check("rect_done", done_rel, 8);
    step();
    check("rect_idle", busy, 0);

    go(158, 118, 200, 127, 2);
    wait_done(50);
    check("clip_n", caplog.size(), 4);
    for (int i = 0; i < caplog.size() && i < 4; i++)
      check("clip_px", caplog[i].x * 256 + caplog[i].y, cx[i] * 256 + cy[i]);
    step();

    go(9, 0, 3, 5, 1);
    wait_done(20);
    check("empty1_n", caplog.size(), 0);
    check("empty1_done", done_rel, 2);
    step();
    go(170, 0, 175, 5, 1);
    wait_done(20);
    check("empty2_n", caplog.size(), 0);
    check("empty2_done", done_rel, 2);
    step();

    go(0, 0, 9, 9, 4);
    repeat (15) step();
    abort = 1;
    step();
    abort = 0;
    check("abort_n", caplog.size(), 15);
    if (caplog.size() > 0)
      check("abort_px", caplog[caplog.size()-1].x * 256 + caplog[caplog.size()-1].y,
            4 * 256 + 1);
    check("abort_nodone", done_rel, -1);
    check("abort_idle", busy, 0);
    go(2, 3, 4, 4, 6);
    wait_done(50);
    check("after_abort_n", caplog.size(), 6);
    step();

    go(10, 20, 13, 22, 7);
    for (int i = 0; i < 60 && done_rel < 0; i++) begin
      start = 1'($urandom);
      x0 = 8'($urandom);
      y0 = 7'($urandom);
      step();
    end
    start = 0;
    check("busy_start_n", caplog.size(), 12);
    check("busy_start_done", done_rel, 14);
    repeat (5) step();

    go(0, 0, 20, 20, 5);
    repeat (10) step();
    #2 resetb = 0;
    #1 check_outs_zero("midrst");
    step();
    step();
    resetb = 1;
    step();
    go(1, 1, 3, 2, 3);
    wait_done(50);
    check("post_rst_n", caplog.size(), 6);
    step();

    go(0, 0, 159, 119, 0);
    wait_done(20000);
    check("full_n", caplog.size(), 19200);
    if (caplog.size() > 0)
      check("full_last", caplog[caplog.size()-1].x * 256 + caplog[caplog.size()-1].y,
            159 * 256 + 119);
    check("full_done", done_rel, 2 + 19200);
    step();

    for (int k = 0; k < 40; k++) begin
      int ax0, ay0, ax1, ay1;
      bit seen_idle;
      ax0 = $urandom_range(0, 175);
      ay0 = $urandom_range(0, 127);
      ax1 = ($urandom % 8 == 0) ? $urandom_range(0, 255) : ax0 + $urandom_range(0, 12);
      ay1 = ($urandom % 8 == 0) ? $urandom_range(0, 127) : ay0 + $urandom_range(0, 10);
      if (ax1 > 255) ax1 = 255;
      if (ay1 > 127) ay1 = 127;
      go(ax0, ay0, ax1, ay1, $urandom_range(0, 7));
      seen_idle = 0;
      for (int i = 0; i < 400 && !seen_idle; i++) begin
        abort = ($urandom % 25 == 0);
        start = ($urandom % 3 == 0);
        step();
        seen_idle = !busy;
      end
      abort = 0;
      start = 0;
      check("rand_idle", seen_idle, 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
